// File: rtl/ndn_pkg.sv
// ndn_pkg -- shared types for the NDN pending-interest-table CAM.
//
// Holds the response-code and FSM-state enums, the stored table entry
// layout, and the prefix-mask helper. The entry struct is sized by the
// PIT_* constants below; the CAM's width parameters default to these, so a
// different prefix/length/face width is changed here, not per instance.
package ndn_pkg;

  localparam int PIT_PREFIX_W = 64;
  localparam int PIT_LEN_W    = 6;
  localparam int PIT_FACES    = 4;

  typedef enum logic [2:0] {
    RSP_INSERT    = 3'd0,
    RSP_AGGREGATE = 3'd1,
    RSP_FULL      = 3'd2,
    RSP_BADLEN    = 3'd3,
    RSP_HIT       = 3'd4,
    RSP_MISS      = 3'd5
  } rsp_code_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MATCH  = 2'd1,
    ST_COMMIT = 2'd2
  } pit_state_t;

  typedef struct packed {
    logic                    valid;
    logic [PIT_LEN_W-1:0]    len;
    logic [PIT_PREFIX_W-1:0] prefix;
    logic [PIT_FACES-1:0]    faces;
  } pit_entry_t;

  // Ones in the top 'len' bit positions (prefixes are left-aligned).
  // A shift of PIT_PREFIX_W or more yields all ones, which is the full-width case.
  function automatic logic [PIT_PREFIX_W-1:0] prefix_mask(input logic [PIT_LEN_W-1:0] len);
    return ~({PIT_PREFIX_W{1'b1}} >> len);
  endfunction

endpackage

// File: rtl/ndn_prefix_match.sv
// ndn_prefix_match -- masked compare of one PIT entry against a request.
//
// Ports:
//   entry_valid/entry_len/entry_prefix : stored entry fields
//   req_len/req_prefix                 : captured request fields
//   req_mask                           : ones over the top req_len bits
//   hit                                : entry valid, lengths equal, masked prefixes equal
module ndn_prefix_match #(
  parameter int PREFIX_W = 64,
  parameter int LEN_W    = 6
) (
  input  logic                entry_valid,
  input  logic [LEN_W-1:0]    entry_len,
  input  logic [PREFIX_W-1:0] entry_prefix,
  input  logic [LEN_W-1:0]    req_len,
  input  logic [PREFIX_W-1:0] req_prefix,
  input  logic [PREFIX_W-1:0] req_mask,
  output logic                hit
);

  // Bits below the prefix length are don't-care on both sides.
  assign hit = entry_valid
            && (entry_len == req_len)
            && (((entry_prefix ^ req_prefix) & req_mask) == '0);

endmodule

// File: rtl/ndn_pit_cam.sv
// ndn_pit_cam -- NDN pending interest table with a fully parallel CAM lookup.
//
// Interests insert or aggregate a name prefix with a face bitmap; data
// lookups consume a matching entry and return the faces to forward to.
// Each accepted request walks IDLE -> MATCH -> COMMIT -> IDLE, and the
// response is registered on the COMMIT->IDLE edge.
//
// Handshake: a request transfers on a rising edge where valid and ready are
// both high; ready depends only on FSM state (and, for interests, on
// dat_valid, since data wins a tie) and never on the same port's valid.
// Request fields are captured on that edge and may change afterwards.
//
// Ports:
//   clk, rst                           : clock, async active-high reset
//   int_valid/int_ready/int_prefix/int_len/int_face : interest request
//   dat_valid/dat_ready/dat_prefix/dat_len           : data lookup
//   rsp_valid/rsp_code/rsp_entry/rsp_faces           : one-cycle response
//   occupancy                          : number of valid entries
//   expire_valid/expire_entry/expire_faces           : lifetime expiry pulse
//   dbg_state                          : current FSM state (pit_state_t)
//
// Build option: define NDN_PIT_TIMEOUT_EN to add per-entry lifetime counters.
// Without it, entries persist until a data hit and expire_* are constant 0.
module ndn_pit_cam
  import ndn_pkg::*;
#(
  parameter int PREFIX_W = PIT_PREFIX_W,
  parameter int LEN_W    = PIT_LEN_W,
  parameter int ENTRIES  = 8,
  parameter int FACES    = PIT_FACES,
  parameter int LIFETIME = 1000,
  localparam int IDX_W   = $clog2(ENTRIES),
  localparam int FACE_W  = $clog2(FACES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                int_valid,
  output logic                int_ready,
  input  logic [PREFIX_W-1:0] int_prefix,
  input  logic [LEN_W-1:0]    int_len,
  input  logic [FACE_W-1:0]   int_face,
  input  logic                dat_valid,
  output logic                dat_ready,
  input  logic [PREFIX_W-1:0] dat_prefix,
  input  logic [LEN_W-1:0]    dat_len,
  output logic                rsp_valid,
  output logic [2:0]          rsp_code,
  output logic [IDX_W-1:0]    rsp_entry,
  output logic [FACES-1:0]    rsp_faces,
  output logic [IDX_W:0]      occupancy,
  output logic                expire_valid,
  output logic [IDX_W-1:0]    expire_entry,
  output logic [FACES-1:0]    expire_faces,
  output logic [1:0]          dbg_state
);

  pit_state_t          state_q;
  pit_entry_t          table_q [ENTRIES];

  logic                req_is_data_q;
  logic [PREFIX_W-1:0] req_prefix_q;
  logic [LEN_W-1:0]    req_len_q;
  logic [FACE_W-1:0]   req_face_q;

  // Lookup results registered at the MATCH->COMMIT edge.
  logic                hit_q;
  logic                free_q;
  logic                len_ok_q;
  logic [IDX_W-1:0]    hit_idx_q;
  logic [IDX_W-1:0]    free_idx_q;

  logic [IDX_W:0]      occ_q;
  logic                rsp_valid_q;
  rsp_code_t           rsp_code_q;
  logic [IDX_W-1:0]    rsp_entry_q;
  logic [FACES-1:0]    rsp_faces_q;

  logic                dat_fire;
  logic                int_fire;
  logic [PREFIX_W-1:0] req_mask;
  logic [ENTRIES-1:0]  hit_vec;
  logic                hit_any;
  logic                free_any;
  logic [IDX_W-1:0]    hit_idx;
  logic [IDX_W-1:0]    free_idx;
  logic                len_ok;
  logic [FACES-1:0]    face_bit;
  logic [FACES-1:0]    agg_faces;

  assign dat_ready = !rst && (state_q == ST_IDLE);
  assign int_ready = !rst && (state_q == ST_IDLE) && !dat_valid;
  assign dat_fire  = dat_valid && dat_ready;
  assign int_fire  = int_valid && int_ready;

  assign req_mask  = prefix_mask(req_len_q);
  assign len_ok    = (req_len_q != '0) && (int'(req_len_q) <= PREFIX_W);

  for (genvar g = 0; g < ENTRIES; g++) begin : g_match
    ndn_prefix_match #(
      .PREFIX_W(PREFIX_W),
      .LEN_W   (LEN_W)
    ) u_match (
      .entry_valid (table_q[g].valid),
      .entry_len   (table_q[g].len),
      .entry_prefix(table_q[g].prefix),
      .req_len     (req_len_q),
      .req_prefix  (req_prefix_q),
      .req_mask    (req_mask),
      .hit         (hit_vec[g])
    );
  end

  // Lowest index wins for both the hit and the free slot: scan downwards so
  // the last assignment is the lowest matching index.
  always_comb begin
    hit_any  = 1'b0;
    hit_idx  = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        hit_any = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!table_q[i].valid) begin
        free_any = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    face_bit             = '0;
    face_bit[req_face_q] = 1'b1;
    agg_faces            = table_q[hit_idx_q].faces | face_bit;
  end

`ifdef NDN_PIT_TIMEOUT_EN
  localparam int CNT_W = $clog2(LIFETIME + 1);

  logic [CNT_W-1:0]   life_q [ENTRIES];
  logic [ENTRIES-1:0] load_vec;
  logic               exp_any;
  logic [IDX_W-1:0]   exp_idx;
  logic               expire_valid_q;
  logic [IDX_W-1:0]   expire_entry_q;
  logic [FACES-1:0]   expire_faces_q;

  // Reload the lifetime of the entry an interest inserts into or aggregates on.
  always_comb begin
    load_vec = '0;
    if (state_q == ST_COMMIT && len_ok_q && !req_is_data_q) begin
      if (hit_q)
        load_vec[hit_idx_q] = 1'b1;
      else if (free_q)
        load_vec[free_idx_q] = 1'b1;
    end
  end

  always_comb begin
    exp_any = 1'b0;
    exp_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (table_q[i].valid && life_q[i] == '0) begin
        exp_any = 1'b1;
        exp_idx = IDX_W'(i);
      end
    end
  end

  // Counters saturate at zero; an expired entry waits there until the FSM
  // has a quiet IDLE cycle to retire it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) life_q[i] <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (load_vec[i])
          life_q[i] <= CNT_W'(LIFETIME - 1);
        else if (life_q[i] != '0)
          life_q[i] <= life_q[i] - 1'b1;
      end
    end
  end

  assign expire_valid = expire_valid_q;
  assign expire_entry = expire_entry_q;
  assign expire_faces = expire_faces_q;
`else
  assign expire_valid = 1'b0;
  assign expire_entry = '0;
  assign expire_faces = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= '0;
      req_is_data_q <= 1'b0;
      req_prefix_q  <= '0;
      req_len_q     <= '0;
      req_face_q    <= '0;
      hit_q         <= 1'b0;
      free_q        <= 1'b0;
      len_ok_q      <= 1'b0;
      hit_idx_q     <= '0;
      free_idx_q    <= '0;
      occ_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_code_q    <= RSP_INSERT;
      rsp_entry_q   <= '0;
      rsp_faces_q   <= '0;
`ifdef NDN_PIT_TIMEOUT_EN
      expire_valid_q <= 1'b0;
      expire_entry_q <= '0;
      expire_faces_q <= '0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
`ifdef NDN_PIT_TIMEOUT_EN
      expire_valid_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (dat_fire) begin
            req_is_data_q <= 1'b1;
            req_prefix_q  <= dat_prefix;
            req_len_q     <= dat_len;
            req_face_q    <= '0;
            state_q       <= ST_MATCH;
          end else if (int_fire) begin
            req_is_data_q <= 1'b0;
            req_prefix_q  <= int_prefix;
            req_len_q     <= int_len;
            req_face_q    <= int_face;
            state_q       <= ST_MATCH;
          end
`ifdef NDN_PIT_TIMEOUT_EN
          else if (exp_any) begin
            expire_valid_q          <= 1'b1;
            expire_entry_q          <= exp_idx;
            expire_faces_q          <= table_q[exp_idx].faces;
            table_q[exp_idx].valid  <= 1'b0;
            table_q[exp_idx].faces  <= '0;
            occ_q                   <= occ_q - 1'b1;
          end
`endif
        end

        ST_MATCH: begin
          hit_q      <= hit_any;
          hit_idx_q  <= hit_idx;
          free_q     <= free_any;
          free_idx_q <= free_idx;
          len_ok_q   <= len_ok;
          state_q    <= ST_COMMIT;
        end

        ST_COMMIT: begin
          rsp_valid_q <= 1'b1;
          rsp_entry_q <= '0;
          rsp_faces_q <= '0;
          if (!len_ok_q) begin
            rsp_code_q <= RSP_BADLEN;
          end else if (req_is_data_q) begin
            if (hit_q) begin
              rsp_code_q                <= RSP_HIT;
              rsp_entry_q               <= hit_idx_q;
              rsp_faces_q               <= table_q[hit_idx_q].faces;
              table_q[hit_idx_q].valid  <= 1'b0;
              table_q[hit_idx_q].faces  <= '0;
              occ_q                     <= occ_q - 1'b1;
            end else begin
              rsp_code_q <= RSP_MISS;
            end
          end else if (hit_q) begin
            rsp_code_q               <= RSP_AGGREGATE;
            rsp_entry_q              <= hit_idx_q;
            rsp_faces_q              <= agg_faces;
            table_q[hit_idx_q].faces <= agg_faces;
          end else if (free_q) begin
            rsp_code_q                 <= RSP_INSERT;
            rsp_entry_q                <= free_idx_q;
            rsp_faces_q                <= face_bit;
            table_q[free_idx_q].valid  <= 1'b1;
            table_q[free_idx_q].len    <= req_len_q;
            table_q[free_idx_q].prefix <= req_prefix_q & req_mask;
            table_q[free_idx_q].faces  <= face_bit;
            occ_q                      <= occ_q + 1'b1;
          end else begin
            rsp_code_q <= RSP_FULL;
          end
          state_q <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_code  = rsp_code_q;
  assign rsp_entry = rsp_entry_q;
  assign rsp_faces = rsp_faces_q;
  assign occupancy = occ_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ndn_pit_cam.sv
// tb_ndn_pit_cam -- directed, table-driven bench for ndn_pit_cam
// (PREFIX_W 64, LEN_W 6, ENTRIES 8, FACES 4, LIFETIME 16).
module tb_ndn_pit_cam;

  localparam int PREFIX_W = 64;
  localparam int LEN_W    = 6;
  localparam int ENTRIES  = 8;
  localparam int FACES    = 4;
  localparam int LIFETIME = 16;

  localparam logic [2:0] C_INSERT = 3'd0;
  localparam logic [2:0] C_AGG    = 3'd1;
  localparam logic [2:0] C_FULL   = 3'd2;
  localparam logic [2:0] C_BADLEN = 3'd3;
  localparam logic [2:0] C_HIT    = 3'd4;
  localparam logic [2:0] C_MISS   = 3'd5;

  logic                clk;
  logic                rst;
  logic                int_valid;
  logic                int_ready;
  logic [PREFIX_W-1:0] int_prefix;
  logic [LEN_W-1:0]    int_len;
  logic [1:0]          int_face;
  logic                dat_valid;
  logic                dat_ready;
  logic [PREFIX_W-1:0] dat_prefix;
  logic [LEN_W-1:0]    dat_len;
  logic                rsp_valid;
  logic [2:0]          rsp_code;
  logic [2:0]          rsp_entry;
  logic [3:0]          rsp_faces;
  logic [3:0]          occupancy;
  logic                expire_valid;
  logic [2:0]          expire_entry;
  logic [3:0]          expire_faces;
  logic [1:0]          dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // Expected response: {code, entry, faces, occupancy}.
  logic [13:0] exp_q[$];

  typedef struct {
    logic          is_data;
    logic [63:0]   prefix;
    logic [5:0]    len;
    logic [1:0]    face;
    logic [2:0]    code;
    logic [2:0]    entry;
    logic [3:0]    faces;
    logic [3:0]    occ;
  } vec_t;

  vec_t vecs[$];

  ndn_pit_cam #(
    .PREFIX_W(PREFIX_W),
    .LEN_W   (LEN_W),
    .ENTRIES (ENTRIES),
    .FACES   (FACES),
    .LIFETIME(LIFETIME)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .int_valid   (int_valid),
    .int_ready   (int_ready),
    .int_prefix  (int_prefix),
    .int_len     (int_len),
    .int_face    (int_face),
    .dat_valid   (dat_valid),
    .dat_ready   (dat_ready),
    .dat_prefix  (dat_prefix),
    .dat_len     (dat_len),
    .rsp_valid   (rsp_valid),
    .rsp_code    (rsp_code),
    .rsp_entry   (rsp_entry),
    .rsp_faces   (rsp_faces),
    .occupancy   (occupancy),
    .expire_valid(expire_valid),
    .expire_entry(expire_entry),
    .expire_faces(expire_faces),
    .dbg_state   (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, expected finish before 2ms");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic is_data, input logic [63:0] p, input logic [5:0] l,
                              input logic [1:0] f, input logic [2:0] c, input logic [2:0] e,
                              input logic [3:0] fc, input logic [3:0] o);
    vec_t v;
    v.is_data = is_data; v.prefix = p; v.len = l; v.face = f;
    v.code = c; v.entry = e; v.faces = fc; v.occ = o;
    return v;
  endfunction

  // Wait for rsp_valid (bounded), then compare against the head of exp_q.
  task automatic wait_rsp(input string name, input int exp_lat);
    int k;
    logic [13:0] e;
    k = 1;
    while (!rsp_valid && k < 12) begin
      @(negedge clk);
      k++;
    end
    check({name, " rsp_valid"}, 64'(rsp_valid), 64'd1);
    if (exp_lat > 0) check({name, " latency"}, 64'(k), 64'(exp_lat));
    if (exp_q.size() == 0) begin
      check({name, " exp_q"}, 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      check({name, " code"},  64'(rsp_code),  64'(e[13:11]));
      check({name, " entry"}, 64'(rsp_entry), 64'(e[10:8]));
      check({name, " faces"}, 64'(rsp_faces), 64'(e[7:4]));
      check({name, " occ"},   64'(occupancy), 64'(e[3:0]));
    end
  endtask

  // Driver: present one request, hold it until the accepting edge, then
  // track the response.
  task automatic do_req(input vec_t v, input string name);
    int k;
    @(negedge clk);
    if (v.is_data) begin
      dat_valid = 1'b1; dat_prefix = v.prefix; dat_len = v.len;
    end else begin
      int_valid = 1'b1; int_prefix = v.prefix; int_len = v.len; int_face = v.face;
    end
    #1;
    k = 0;
    while (!(v.is_data ? dat_ready : int_ready) && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) begin
      check({name, " ready timeout"}, 64'd0, 64'd1);
      dat_valid = 1'b0;
      int_valid = 1'b0;
      void'(exp_q.pop_front());
      return;
    end
    @(negedge clk);
    dat_valid = 1'b0;
    int_valid = 1'b0;
    wait_rsp(name, 3);
  endtask

  initial begin
    int   k;
    int   seen;
    vec_t v;

    rst = 1'b1;
    int_valid = 1'b0; int_prefix = '0; int_len = '0; int_face = '0;
    dat_valid = 1'b0; dat_prefix = '0; dat_len = '0;
    repeat (3) @(negedge clk);
    check("ready low in reset", 64'({int_ready, dat_ready}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("reset occupancy", 64'(occupancy), 64'd0);
    check("reset rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset rsp_fields", 64'({rsp_code, rsp_entry, rsp_faces}), 64'd0);
    check("reset expire", 64'({expire_valid, expire_entry, expire_faces}), 64'd0);
    check("reset state", 64'(dbg_state), 64'd0);
    check("reset ready", 64'({int_ready, dat_ready}), 64'b11);

    // Directed vectors, hand-computed
    vecs.push_back(mk(0, 64'hAB00_0000_0000_0000, 8,  2, C_INSERT, 0, 4'b0100, 1));
    vecs.push_back(mk(0, 64'hAB00_0000_0000_0000, 8,  0, C_AGG,    0, 4'b0101, 1));
    vecs.push_back(mk(0, 64'hAB00_0000_0000_0000, 8,  0, C_AGG,    0, 4'b0101, 1));
    vecs.push_back(mk(0, 64'hAB12_3400_0000_0000, 8,  1, C_AGG,    0, 4'b0111, 1));
    vecs.push_back(mk(1, 64'hABFF_FFFF_FFFF_FFFF, 8,  0, C_HIT,    0, 4'b0111, 0));
    vecs.push_back(mk(1, 64'hAB00_0000_0000_0000, 8,  0, C_MISS,   0, 4'b0000, 0));
    vecs.push_back(mk(0, 64'hAB00_0000_0000_0000, 0,  1, C_BADLEN, 0, 4'b0000, 0));
    vecs.push_back(mk(0, 64'hAB00_0000_0000_0000, 16, 3, C_INSERT, 0, 4'b1000, 1));
    vecs.push_back(mk(0, 64'hAB00_0000_0000_0000, 8,  1, C_INSERT, 1, 4'b0010, 2));
    vecs.push_back(mk(1, 64'hAB00_0000_0000_0000, 16, 0, C_HIT,    0, 4'b1000, 1));
    vecs.push_back(mk(0, 64'hCD00_0000_0000_0000, 8,  0, C_INSERT, 0, 4'b0001, 2));
    vecs.push_back(mk(1, 64'hAB00_0000_0000_0000, 8,  0, C_HIT,    1, 4'b0010, 1));
    vecs.push_back(mk(1, 64'hCD00_0000_0000_0000, 8,  0, C_HIT,    0, 4'b0001, 0));
    vecs.push_back(mk(0, 64'hFFFF_FFFF_FFFF_FFFF, 63, 1, C_INSERT, 0, 4'b0010, 1));
    vecs.push_back(mk(1, 64'hFFFF_FFFF_FFFF_FFFE, 63, 0, C_HIT,    0, 4'b0010, 0));
    vecs.push_back(mk(0, 64'hFFFF_FFFF_FFFF_FFFF, 0,  2, C_BADLEN, 0, 4'b0000, 0));
    // Fill: eight inserts into entries 0..7, then FULL.
    for (int i = 0; i < 9; i++) begin
      if (i < 8)
        vecs.push_back(mk(0, {8'(i + 1), 56'h0}, 8, 2'(i % 4), C_INSERT, 3'(i),
                          4'b0001 << (i % 4), 4'(i + 1)));
      else
        vecs.push_back(mk(0, {8'(i + 1), 56'h0}, 8, 2'(i % 4), C_FULL, 0, 4'b0000, 8));
    end

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      exp_q.push_back({v.code, v.entry, v.faces, v.occ});
      do_req(v, $sformatf("vec%0d", i));
    end

    // Simultaneous data + interest: data wins, interest follows.
    @(negedge clk);
    dat_valid = 1'b1; dat_prefix = 64'h0100_0000_0000_0000; dat_len = 8;
    int_valid = 1'b1; int_prefix = 64'h7700_0000_0000_0000; int_len = 8; int_face = 3;
    #1;
    check("tie int_ready", 64'(int_ready), 64'd0);
    check("tie dat_ready", 64'(dat_ready), 64'd1);
    @(negedge clk);
    dat_valid = 1'b0;
    exp_q.push_back({C_HIT, 3'd0, 4'b0001, 4'd7});
    wait_rsp("tie data", 3);
    check("tie int_ready after", 64'(int_ready), 64'd1);
    @(negedge clk);
    int_valid = 1'b0;
    exp_q.push_back({C_INSERT, 3'd0, 4'b1000, 4'd8});
    wait_rsp("tie interest", 3);

    // Reset while a request sits in MATCH: no response, table cleared.
    @(negedge clk);
    int_valid = 1'b1; int_prefix = 64'h5500_0000_0000_0000; int_len = 8; int_face = 1;
    @(negedge clk);
    int_valid = 1'b0;
    check("pre-reset state MATCH", 64'(dbg_state), 64'd1);
    rst = 1'b1;
    #1;
    check("mid reset ready", 64'({int_ready, dat_ready}), 64'd0);
    check("mid reset occupancy", 64'(occupancy), 64'd0);
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("reset drops rsp", 64'(seen), 64'd0);
    check("reset state idle", 64'(dbg_state), 64'd0);

    // Table is empty again, so this lands in entry 0.
    exp_q.push_back({C_INSERT, 3'd0, 4'b0010, 4'd1});
    do_req(mk(0, 64'h5500_0000_0000_0000, 8, 1, C_INSERT, 0, 4'b0010, 1), "post reset");

`ifdef NDN_PIT_TIMEOUT_EN
    k = 0;
    while (!expire_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("expire delay", 64'(k), 64'(LIFETIME));
    check("expire entry", 64'(expire_entry), 64'd0);
    check("expire faces", 64'(expire_faces), 64'b0010);
    check("expire occupancy", 64'(occupancy), 64'd0);
    @(negedge clk);
    check("expire pulse width", 64'(expire_valid), 64'd0);
`else
    seen = 0;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (expire_valid) seen++;
    end
    check("no expiry", 64'(seen), 64'd0);
    check("entry persists", 64'(occupancy), 64'd1);
`endif

    check("exp_q drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
